load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage consumer of the decoder's LdStCtrl/MemWrite encoding.
- Takes one decoded load/store (LdStCtrl code, byte address, store data) and drives a word-wide data-memory port with a valid/ack handshake.
- Generates byte-lane write enables and replicated store data; extracts and sign- or zero-extends load data.
- Stalls the pipeline while the access is outstanding.

Parameters:
- TIMEOUT, 255: maximum ACCESS cycles waited for mem_ack. Used only with LSU_TIMEOUT_EN. Legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  memory op present this cycle
- ldst_ctrl  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- addr  in  32  byte address (ALU result)
- store_data  in  32  rt value
- stall  out  1  freeze upstream pipeline
- load_data  out  32  extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- misalign  out  1  one-cycle pulse, misaligned request dropped
- bus_err  out  1  one-cycle pulse, access timed out
- mem_req  out  1  memory request
- mem_addr  out  32  word address: {addr[31:2],2'b00}
- mem_we  out  4  byte write enables, lane k = bits [8k+7:8k]
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  request completed; mem_rdata valid on loads
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, any state): go to IDLE. All outputs 0, including load_data and the latched request.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, req_valid=1:
  - Latch ldst_ctrl, addr and store_data.
  - Misaligned request (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to DONE with the misalign flag set; no memory access.
  - Otherwise: go to ACCESS.
- IDLE, req_valid=0: stay in IDLE.
- ACCESS:
  - mem_req=1. mem_addr, mem_we and mem_wdata come from the latched values and stay stable until ack.
  - mem_ack=1: go to DONE, mem_req drops next cycle. For loads, register the extracted value into load_data.
  - Ack on the first ACCESS cycle is legal (zero wait states).
- DONE (one cycle):
  - load_valid=1 if the op was a load and not misaligned.
  - misalign=1 if flagged.
  - Return to IDLE.
- stall = (IDLE & req_valid) | ACCESS. stall=0 in DONE so the pipeline advances with load_data.
- Latency for an aligned op with ack in ACCESS cycle N (acceptance = cycle 0, ACCESS starts cycle 1): load_valid in cycle N+1. Misaligned: misalign in cycle 1.
- Store enables:
  - SB: 0001<<addr[1:0]
  - SH: 0011<<addr[1:0] (i.e. 0011 or 1100)
  - SW: 1111
  - loads: 0000
- Store data:
  - SB: {4{store_data[7:0]}}
  - SH: {2{store_data[15:0]}}
  - SW: store_data
  - loads: mem_wdata=0
- Load extraction:
  - Byte lane addr[1:0]; halfword lane addr[1] (bits 15:0 or 31:16).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- load_data holds its value until the next completed load. Stores and misaligned ops do not change it.
- mem_ack outside ACCESS is ignored.
- req_valid is sampled only in IDLE; requests in ACCESS/DONE are the upstream's responsibility (it is stalled).

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT with no ack: drop mem_req and go to DONE with bus_err=1 for that cycle. No load_valid; load_data unchanged.
  - mem_ack in the same cycle as the terminal count wins: normal completion, no bus_err.
- Undefined: no counter; ACCESS waits indefinitely; bus_err tied 0.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x80FF1234, ack after 2 cycles:
  - mem_addr=0x1000, mem_we=0000
  - load_data=0xFFFFFF80, load_valid one cycle after ack
  - stall high from acceptance through ack
- LHU, addr=0x2002, mem_rdata=0x8001ABCD, zero-wait ack -> load_data=0x00008001, load_valid in cycle 2.
- SB, addr=0x3001, store_data=0x123456AB -> mem_we=0010, mem_wdata=0xABABABAB; SH at 0x3002 -> mem_we=1100, mem_wdata=0x56AB56AB.
- LW, addr=0x4002 -> no mem_req, misalign=1 in cycle 1, stall drops, load_data unchanged.
- Assert rst mid-ACCESS of SW 0x5000 -> mem_req/mem_we drop immediately (async), FSM in IDLE, no load_valid after release.
- With LSU_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req high 4 cycles, bus_err pulse, IDLE; ack on 4th cycle -> completion, bus_err=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one decoded access at a time over a valid/ack word port.
// Define LSU_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles without an ack.
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [2:0]  ldst_ctrl,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] LP_LB  = 3'd0;
   localparam logic [2:0] LP_LH  = 3'd1;
   localparam logic [2:0] LP_LW  = 3'd2;
   localparam logic [2:0] LP_LBU = 3'd3;
   localparam logic [2:0] LP_LHU = 3'd4;
   localparam logic [2:0] LP_SB  = 3'd5;
   localparam logic [2:0] LP_SH  = 3'd6;
   localparam logic [2:0] LP_SW  = 3'd7;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("load_store_unit: TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [2:0]  r_ctrl;
   logic [31:0] r_addr;
   logic [31:0] r_sdata;
   logic [31:0] r_load_data;
   logic        r_misalign;
   logic        r_load_done;

   logic        w_misalign_req;
   logic        w_is_load;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;
   logic [3:0]  w_we;
   logic [31:0] w_wdata;
   logic        w_tmo;

`ifdef LSU_TIMEOUT_EN
   logic [7:0]  r_cnt;
   logic        r_bus_err;
   assign w_tmo = (r_state == S_ACCESS) && !mem_ack && (r_cnt == 8'(TIMEOUT - 1));
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_misalign_req = 1'b0;
      case (ldst_ctrl)
         LP_LH, LP_LHU, LP_SH: w_misalign_req = addr[0];
         LP_LW, LP_SW:         w_misalign_req = |addr[1:0];
         default:              w_misalign_req = 1'b0;
      endcase
   end

   assign w_is_load = (r_ctrl <= LP_LHU);
   assign w_byte    = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
   assign w_half    = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      w_ext = 32'h0;
      case (r_ctrl)
         LP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
         LP_LH:   w_ext = {{16{w_half[15]}}, w_half};
         LP_LW:   w_ext = mem_rdata;
         LP_LBU:  w_ext = {24'h0, w_byte};
         LP_LHU:  w_ext = {16'h0, w_half};
         default: w_ext = 32'h0;
      endcase
   end

   // Lane enables and replicated data are derived only from the latched request.
   always_comb begin
      w_we    = 4'b0000;
      w_wdata = 32'h0;
      case (r_ctrl)
         LP_SB: begin
            w_we    = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_sdata[7:0]}};
         end
         LP_SH: begin
            w_we    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_sdata[15:0]}};
         end
         LP_SW: begin
            w_we    = 4'b1111;
            w_wdata = r_sdata;
         end
         default: begin
            w_we    = 4'b0000;
            w_wdata = 32'h0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) w_state_next = w_misalign_req ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            if (mem_ack || w_tmo) w_state_next = S_DONE;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl      <= 3'd0;
         r_addr      <= 32'h0;
         r_sdata     <= 32'h0;
         r_load_data <= 32'h0;
         r_misalign  <= 1'b0;
         r_load_done <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         r_cnt       <= 8'd0;
         r_bus_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_ctrl      <= ldst_ctrl;
                  r_addr      <= addr;
                  r_sdata     <= store_data;
                  r_misalign  <= w_misalign_req;
                  r_load_done <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                  r_cnt       <= 8'd0;
                  r_bus_err   <= 1'b0;
`endif
               end
            end
            S_ACCESS: begin
               if (mem_ack) begin
                  if (w_is_load) begin
                     r_load_data <= w_ext;
                     r_load_done <= 1'b1;
                  end
`ifdef LSU_TIMEOUT_EN
               end else if (w_tmo) begin
                  r_bus_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
`endif
               end
            end
            default: begin
               r_misalign  <= 1'b0;
               r_load_done <= 1'b0;
`ifdef LSU_TIMEOUT_EN
               r_bus_err   <= 1'b0;
`endif
            end
         endcase
      end
   end

   always_comb begin
      stall      = ((r_state == S_IDLE) && req_valid) || (r_state == S_ACCESS);
      mem_req    = (r_state == S_ACCESS);
      mem_addr   = {r_addr[31:2], 2'b00};
      mem_we     = (r_state == S_ACCESS) ? w_we : 4'b0000;
      mem_wdata  = (r_state == S_ACCESS) ? w_wdata : 32'h0;
      load_data  = r_load_data;
      load_valid = (r_state == S_DONE) && r_load_done;
      misalign   = (r_state == S_DONE) && r_misalign;
`ifdef LSU_TIMEOUT_EN
      bus_err    = (r_state == S_DONE) && r_bus_err;
`else
      bus_err    = 1'b0;
`endif
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit; expected results queued at issue, popped at completion.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  ldst_ctrl = 3'd0;
   logic [31:0] addr = 32'h0;
   logic [31:0] store_data = 32'h0;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        misalign;
   logic        bus_err;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int n_checks = 0;
   int n_errors = 0;

   localparam int BUDGET = 40;

   typedef struct {
      logic [2:0]  flags;   // {load_valid, misalign, bus_err}
      logic [31:0] ld;
      int          cyc;
   } exp_t;
   exp_t sb_q[$];

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .ldst_ctrl(ldst_ctrl),
      .addr(addr), .store_data(store_data), .stall(stall), .load_data(load_data),
      .load_valid(load_valid), .misalign(misalign), .bus_err(bus_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int ack_cyc, input logic [3:0] ewe,
                         input logic [31:0] ewd, input logic [2:0] eflags,
                         input logic [31:0] eld, input int ecyc);
      exp_t e;
      exp_t got;
      int   cyc;
      e.flags = eflags;
      e.ld    = eld;
      e.cyc   = ecyc;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b1; ldst_ctrl = c; addr = a; store_data = sd; mem_rdata = rd;
      #1 chk("stall_accept", {31'h0, stall}, 32'h1);
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      while (mem_req === 1'b1 && cyc <= BUDGET) begin
         chk("mem_addr", mem_addr, {a[31:2], 2'b00});
         chk("mem_we", {28'h0, mem_we}, {28'h0, ewe});
         chk("mem_wdata", mem_wdata, ewd);
         chk("stall_access", {31'h0, stall}, 32'h1);
         mem_ack = (cyc == ack_cyc);
         @(negedge clk);
         mem_ack = 1'b0;
         cyc++;
      end
      got = sb_q.pop_front();
      chk("done_flags", {29'h0, load_valid, misalign, bus_err}, {29'h0, got.flags});
      chk("load_data", load_data, got.ld);
      chk("done_cycle", cyc, got.cyc);
      chk("stall_done", {31'h0, stall}, 32'h0);
      chk("mem_req_done", {31'h0, mem_req}, 32'h0);
      $display("op ctrl=%0d addr=%08h flags=%b load_data=%08h cycle=%0d",
               c, a, {load_valid, misalign, bus_err}, load_data, cyc);
   endtask

   initial begin
      #1;
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_pulses", {29'h0, load_valid, misalign, bus_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      //     ctrl  addr          store_data    rdata         ack we       wdata         flags   load_data     cyc
      run_op(3'd0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2, 4'b0000, 32'h0,        3'b100, 32'hFFFF_FF80, 3);
      run_op(3'd4, 32'h0000_2002, 32'h0,        32'h8001_ABCD, 1, 4'b0000, 32'h0,        3'b100, 32'h0000_8001, 2);
      run_op(3'd5, 32'h0000_3001, 32'h1234_56AB, 32'h0,        1, 4'b0010, 32'hABAB_ABAB, 3'b000, 32'h0000_8001, 2);
      run_op(3'd6, 32'h0000_3002, 32'h1234_56AB, 32'h0,        3, 4'b1100, 32'h56AB_56AB, 3'b000, 32'h0000_8001, 4);
      run_op(3'd2, 32'h0000_4002, 32'h0,        32'hFFFF_FFFF, 1, 4'b0000, 32'h0,        3'b010, 32'h0000_8001, 1);
      run_op(3'd1, 32'h0000_5001, 32'h0,        32'hFFFF_FFFF, 1, 4'b0000, 32'h0,        3'b010, 32'h0000_8001, 1);
      run_op(3'd6, 32'h0000_3001, 32'hFFFF_FFFF, 32'h0,        1, 4'b0000, 32'h0,        3'b010, 32'h0000_8001, 1);
      run_op(3'd1, 32'h0000_6002, 32'h0,        32'h8765_1234, 1, 4'b0000, 32'h0,        3'b100, 32'hFFFF_8765, 2);
      run_op(3'd3, 32'h0000_6001, 32'h0,        32'h0000_9A00, 2, 4'b0000, 32'h0,        3'b100, 32'h0000_009A, 3);
      run_op(3'd0, 32'h0000_6000, 32'h0,        32'hFFFF_FF7F, 1, 4'b0000, 32'h0,        3'b100, 32'h0000_007F, 2);
      run_op(3'd4, 32'h0000_6000, 32'h0,        32'h1234_F00F, 1, 4'b0000, 32'h0,        3'b100, 32'h0000_F00F, 2);
      run_op(3'd2, 32'h0000_7000, 32'h0,        32'hDEAD_BEEF, 1, 4'b0000, 32'h0,        3'b100, 32'hDEAD_BEEF, 2);
      run_op(3'd7, 32'h0000_7004, 32'hCAFE_F00D, 32'h0,        2, 4'b1111, 32'hCAFE_F00D, 3'b000, 32'hDEAD_BEEF, 3);
      run_op(3'd5, 32'h0000_7003, 32'h0000_0011, 32'h0,        1, 4'b1000, 32'h1111_1111, 3'b000, 32'hDEAD_BEEF, 2);

      // Ack while idle must be ignored.
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ack_pulses", {29'h0, load_valid, misalign, bus_err}, 32'h0);
         chk("idle_ack_req", {30'h0, mem_req, stall}, 32'h0);
      end
      mem_ack = 1'b0;
      chk("idle_ack_load_data", load_data, 32'hDEAD_BEEF);

      // Asynchronous reset in the middle of a store access.
      @(negedge clk);
      req_valid = 1'b1; ldst_ctrl = 3'd7; addr = 32'h0000_5000; store_data = 32'h0BAD_F00D;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_mid_req_before", {31'h0, mem_req}, 32'h1);
      chk("rst_mid_we_before", {28'h0, mem_we}, 32'hF);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mid_we", {28'h0, mem_we}, 32'h0);
      chk("rst_mid_stall", {31'h0, stall}, 32'h0);
      chk("rst_mid_load_data", load_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_after_pulses", {29'h0, load_valid, misalign, bus_err}, 32'h0);
         chk("rst_after_req", {31'h0, mem_req}, 32'h0);
      end

`ifdef LSU_TIMEOUT_EN
      run_op(3'd2, 32'h0000_8000, 32'h0, 32'h2468_ACE0, 0, 4'b0000, 32'h0, 3'b001, 32'h0, 5);
      run_op(3'd2, 32'h0000_8000, 32'h0, 32'h1357_9BDF, 4, 4'b0000, 32'h0, 3'b100, 32'h1357_9BDF, 5);
      run_op(3'd7, 32'h0000_8004, 32'hA5A5_0F0F, 32'h0, 0, 4'b1111, 32'hA5A5_0F0F, 3'b001, 32'h1357_9BDF, 5);
`else
      run_op(3'd0, 32'h0000_8000, 32'h0, 32'h0000_0080, 10, 4'b0000, 32'h0, 3'b100, 32'hFFFF_FF80, 11);
      run_op(3'd7, 32'h0000_8004, 32'hA5A5_0F0F, 32'h0, 7, 4'b1111, 32'hA5A5_0F0F, 3'b000, 32'hFFFF_FF80, 8);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
